// File: rtl/player_credit_ctrl.sv
// player_credit_ctrl
// Holds the 17-bit player score, accepts single/max bet requests from the
// bet key, debits the score and starts a spin, then credits the payout
// returned by the reel/evaluation stage (saturating at 17'h1FFFF).
//
// Ports:
//   Clock       system clock, rising edge
//   Resetn      synchronous active-low reset
//   bet_key     bet request level, acted on at its rising edge
//   maxbet_sel  1 = max bet, 0 = single bet (sampled with the bet edge)
//   spin_done   one-cycle pulse from the reel stage, payout valid with it
//   payout      credits won
//   coin_in     coin sensor level (only with COIN_INSERT_EN)
//   score       current credit
//   bet_amount  bet latched for the current spin
//   spin_start  one-cycle pulse that starts the reels
//   busy        high while a spin is outstanding
//   no_credit   sticky flag for a rejected bet
//
// Optional feature: define COIN_INSERT_EN to add the coin_in port.
//
// state | meaning
// ------+----------------------------------------------
// IDLE  | waiting for a bet edge
// SPIN  | bet debited, waiting for spin_done and payout

module player_credit_ctrl #(
  parameter int INIT_SCORE = 100,
  parameter int SINGLE_BET = 1,
  parameter int MAX_BET    = 5,
  parameter int COIN_VALUE = 10
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        bet_key,
  input  logic        maxbet_sel,
  input  logic        spin_done,
  input  logic [16:0] payout,
`ifdef COIN_INSERT_EN
  input  logic        coin_in,
`endif
  output logic [16:0] score,
  output logic [2:0]  bet_amount,
  output logic        spin_start,
  output logic        busy,
  output logic        no_credit
);

  typedef enum logic {IDLE = 1'b0, SPIN = 1'b1} state_t;

  localparam logic [16:0] SCORE_MAX = 17'h1FFFF;

  state_t      state, state_nxt;
  logic        bet_key_d;
  logic        bet_edge;
  logic [2:0]  bet_val;
  logic [16:0] score_base;
  // 19 bits so score + payout + coin can never wrap before saturation
  logic [18:0] add_val;
  logic [18:0] sum;
  logic [16:0] score_nxt;
  logic [2:0]  bet_amount_nxt;
  logic        spin_start_nxt;
  logic        no_credit_nxt;

`ifdef COIN_INSERT_EN
  logic coin_d;
  logic coin_edge;
  assign coin_edge = coin_in & ~coin_d;
`endif

  assign bet_edge = bet_key & ~bet_key_d;
  assign bet_val  = maxbet_sel ? 3'(MAX_BET) : 3'(SINGLE_BET);
  assign busy     = (state == SPIN);

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    score_base     = score;
    add_val        = '0;
    bet_amount_nxt = bet_amount;
    spin_start_nxt = 1'b0;
    no_credit_nxt  = no_credit;
    case (state)
      IDLE: begin
        if (bet_edge) begin
          if (score >= {14'd0, bet_val}) begin
            score_base     = score - {14'd0, bet_val};
            bet_amount_nxt = bet_val;
            spin_start_nxt = 1'b1;
            no_credit_nxt  = 1'b0;
            state_nxt      = SPIN;
          end else begin
            no_credit_nxt = 1'b1;
          end
        end
      end
      SPIN: begin
        if (spin_done) begin
          add_val   = {2'b00, payout};
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
`ifdef COIN_INSERT_EN
    // Coin credit stacks on top of any debit or payout in the same cycle;
    // the credit check above already used the pre-coin score.
    if (coin_edge) begin
      add_val       = add_val + 19'(COIN_VALUE);
      no_credit_nxt = 1'b0;
    end
`endif
    sum       = {2'b00, score_base} + add_val;
    score_nxt = (sum > {2'b00, SCORE_MAX}) ? SCORE_MAX : sum[16:0];
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      score      <= 17'(INIT_SCORE);
      bet_amount <= 3'd0;
      spin_start <= 1'b0;
      no_credit  <= 1'b0;
      bet_key_d  <= 1'b0;
    end else begin
      score      <= score_nxt;
      bet_amount <= bet_amount_nxt;
      spin_start <= spin_start_nxt;
      no_credit  <= no_credit_nxt;
      bet_key_d  <= bet_key;
    end
  end

`ifdef COIN_INSERT_EN
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      coin_d <= 1'b0;
    end else begin
      coin_d <= coin_in;
    end
  end
`endif

endmodule

// File: tb/tb_player_credit_ctrl.sv
// Directed testbench for player_credit_ctrl. Inputs change 1 ns after a
// rising edge; outputs are checked at the same point, i.e. reflecting the
// edge that just happened. Define COIN_INSERT_EN to also test coin credit.

module tb_player_credit_ctrl;

  logic        Clock;
  logic        Resetn;
  logic        bet_key;
  logic        maxbet_sel;
  logic        spin_done;
  logic [16:0] payout;
`ifdef COIN_INSERT_EN
  logic        coin_in;
`endif
  logic [16:0] score;
  logic [2:0]  bet_amount;
  logic        spin_start;
  logic        busy;
  logic        no_credit;

  int n_checks;
  int n_fail;

  player_credit_ctrl dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .bet_key    (bet_key),
    .maxbet_sel (maxbet_sel),
    .spin_done  (spin_done),
    .payout     (payout),
`ifdef COIN_INSERT_EN
    .coin_in    (coin_in),
`endif
    .score      (score),
    .bet_amount (bet_amount),
    .spin_start (spin_start),
    .busy       (busy),
    .no_credit  (no_credit)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // One low cycle on bet_key, then a one-cycle high pulse; returns right
  // after the edge that samples the request.
  task automatic do_bet(input logic maxsel);
    bet_key = 1'b0;
    tick();
    maxbet_sel = maxsel;
    bet_key    = 1'b1;
    tick();
    bet_key = 1'b0;
  endtask

  task automatic do_done(input logic [16:0] p);
    spin_done = 1'b1;
    payout    = p;
    tick();
    spin_done = 1'b0;
    payout    = '0;
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    tick();
    tick();
    Resetn = 1'b1;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    Resetn     = 1'b0;
    bet_key    = 1'b0;
    maxbet_sel = 1'b0;
    spin_done  = 1'b0;
    payout     = '0;
`ifdef COIN_INSERT_EN
    coin_in    = 1'b0;
`endif
    #1;
    do_reset();
    check("rst_score", 32'(score), 100);
    check("rst_busy", 32'(busy), 0);
    check("rst_no_credit", 32'(no_credit), 0);
    check("rst_spin_start", 32'(spin_start), 0);
    check("rst_bet_amount", 32'(bet_amount), 0);

    // single bet then payout
    do_bet(1'b0);
    check("single_score", 32'(score), 99);
    check("single_bet_amount", 32'(bet_amount), 1);
    check("single_spin_start", 32'(spin_start), 1);
    check("single_busy", 32'(busy), 1);
    tick();
    check("spin_start_drop", 32'(spin_start), 0);
    do_done(17'd10);
    check("payout_score", 32'(score), 109);
    check("payout_busy", 32'(busy), 0);

    // spin_done in IDLE is ignored
    do_done(17'd7);
    check("idle_done_score", 32'(score), 109);

    // held bet_key produces only one request
    bet_key = 1'b1;
    tick();
    check("held_score", 32'(score), 108);
    tick();
    do_done(17'd0);
    tick();
    tick();
    check("held_again_score", 32'(score), 108);
    check("held_again_busy", 32'(busy), 0);
    bet_key = 1'b0;

    // max bets with zero payout bring score to 3
    for (int i = 0; i < 21; i++) begin
      do_bet(1'b1);
      do_done(17'd0);
    end
    check("drain_score", 32'(score), 3);

    // insufficient credit
    do_bet(1'b1);
    check("nocred_score", 32'(score), 3);
    check("nocred_flag", 32'(no_credit), 1);
    check("nocred_spin_start", 32'(spin_start), 0);
    check("nocred_busy", 32'(busy), 0);
    check("nocred_bet_amount", 32'(bet_amount), 5);
    do_bet(1'b0);
    check("after_nocred_score", 32'(score), 2);
    check("after_nocred_flag", 32'(no_credit), 0);
    check("after_nocred_bet_amount", 32'(bet_amount), 1);
    do_done(17'd131069);
    check("big_payout_score", 32'(score), 131071);

    // busy lockout, then saturating payout
    do_bet(1'b0);
    check("lock_start_score", 32'(score), 131070);
    for (int i = 0; i < 3; i++) begin
      bet_key    = 1'b1;
      maxbet_sel = 1'b1;
      tick();
      bet_key = 1'b0;
      tick();
    end
    check("lock_score", 32'(score), 131070);
    check("lock_busy", 32'(busy), 1);
    check("lock_bet_amount", 32'(bet_amount), 1);
    do_done(17'd5);
    check("sat_score", 32'(score), 131071);
    check("sat_busy", 32'(busy), 0);

    // reset mid-spin; reset wins over a same-cycle spin_done
    do_reset();
    do_bet(1'b1);
    check("mid_bet_score", 32'(score), 95);
    Resetn    = 1'b0;
    spin_done = 1'b1;
    payout    = 17'd50;
    tick();
    Resetn    = 1'b1;
    spin_done = 1'b0;
    payout    = '0;
    do_done(17'd50);
    check("mid_rst_score", 32'(score), 100);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_bet_amount", 32'(bet_amount), 0);

`ifdef COIN_INSERT_EN
    for (int i = 0; i < 20; i++) begin
      do_bet(1'b1);
      do_done(17'd0);
    end
    check("coin_drain_score", 32'(score), 0);
    do_bet(1'b0);
    check("coin_nocred_flag", 32'(no_credit), 1);
    coin_in = 1'b1;
    tick();
    coin_in = 1'b0;
    check("coin_score", 32'(score), 10);
    check("coin_clear_flag", 32'(no_credit), 0);
    tick();
    maxbet_sel = 1'b0;
    bet_key    = 1'b1;
    coin_in    = 1'b1;
    tick();
    bet_key = 1'b0;
    coin_in = 1'b0;
    check("coin_bet_score", 32'(score), 19);
    check("coin_bet_busy", 32'(busy), 1);
    tick();
    coin_in = 1'b1;
    do_done(17'd3);
    coin_in = 1'b0;
    check("coin_done_score", 32'(score), 32);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
